// File: rtl/axi_dram_pkg.sv
// axi_dram_pkg: shared AXI constants and responder state encoding.
`default_nettype none

package axi_dram_pkg;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [2:0] AXI_SIZE_2B     = 3'b001;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/dram_word_mem.sv
// dram_word_mem: word array, synchronous write, asynchronous read, no reset.
`default_nettype none

module dram_word_mem #(
  parameter int MEM_AW     = 12,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [MEM_AW-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [MEM_AW-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [0:(2**MEM_AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

`default_nettype wire

// File: rtl/axi_dram_read_slave.sv
// axi_dram_read_slave: AXI4 read responder with fixed latency, INCR bursts and R backpressure.
`default_nettype none

module axi_dram_read_slave
  import axi_dram_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 16,
  parameter int MEM_AW     = 12,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ID_WIDTH-1:0]   arid_s_inf,
  input  logic [ADDR_WIDTH-1:0] araddr_s_inf,
  input  logic [6:0]            arlen_s_inf,
  input  logic [2:0]            arsize_s_inf,
  input  logic [1:0]            arburst_s_inf,
  input  logic                  arvalid_s_inf,
  output logic                  arready_s_inf,
  output logic [ID_WIDTH-1:0]   rid_s_inf,
  output logic [DATA_WIDTH-1:0] rdata_s_inf,
  output logic [1:0]            rresp_s_inf,
  output logic                  rlast_s_inf,
  output logic                  rvalid_s_inf,
  input  logic                  rready_s_inf,
  input  logic                  bd_we,
  input  logic [MEM_AW-1:0]     bd_addr,
  input  logic [DATA_WIDTH-1:0] bd_wdata
);

  localparam logic [3:0] WAIT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_t                state, state_next;
  logic [MEM_AW-1:0]     idx, rd_idx;
  logic [6:0]            cnt, rd_cnt, len;
  logic [ID_WIDTH-1:0]   id;
  logic                  err;
  logic [3:0]            wcnt;
  logic                  ar_hs, accept, load_beat;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^{araddr_s_inf[ADDR_WIDTH-1:MEM_AW+1], araddr_s_inf[0]};

  assign ar_hs  = (state == IDLE) && arvalid_s_inf && arready_s_inf;
  assign accept = rvalid_s_inf && rready_s_inf;

  dram_word_mem #(
    .MEM_AW    (MEM_AW),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mem (
    .clk  (clk),
    .we   (bd_we),
    .waddr(bd_addr),
    .wdata(bd_wdata),
    .raddr(rd_idx),
    .rdata(mem_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // The first cycle in BURST (rvalid still low) registers beat 0; later beats load on a non-last accept.
  always_comb begin
    state_next = state;
    load_beat  = 1'b0;
    rd_idx     = idx;
    rd_cnt     = cnt;
    case (state)
      IDLE: begin
        if (ar_hs) state_next = (LATENCY > 0) ? WAIT : BURST;
      end
      WAIT: begin
        if (wcnt == 4'd0) state_next = BURST;
      end
      BURST: begin
        if (!rvalid_s_inf) begin
          load_beat = 1'b1;
        end else if (accept) begin
          if (rlast_s_inf) begin
            state_next = IDLE;
          end else begin
            load_beat = 1'b1;
            rd_idx    = MEM_AW'(idx + 1'b1);
            rd_cnt    = 7'(cnt + 7'd1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arready_s_inf <= 1'b0;
      rvalid_s_inf  <= 1'b0;
      rlast_s_inf   <= 1'b0;
      rid_s_inf     <= '0;
      rdata_s_inf   <= '0;
      rresp_s_inf   <= AXI_RESP_OKAY;
      idx           <= '0;
      cnt           <= '0;
      len           <= '0;
      id            <= '0;
      err           <= 1'b0;
      wcnt          <= '0;
    end else begin
      arready_s_inf <= (state_next == IDLE);
      if (ar_hs) begin
        id   <= arid_s_inf;
        len  <= arlen_s_inf;
        err  <= (arburst_s_inf != AXI_BURST_INCR) || (arsize_s_inf != AXI_SIZE_2B);
        idx  <= araddr_s_inf[MEM_AW:1];
        cnt  <= '0;
        wcnt <= WAIT_LOAD;
      end
      if ((state == WAIT) && (wcnt != 4'd0)) wcnt <= wcnt - 4'd1;
      if (load_beat) begin
        idx          <= rd_idx;
        cnt          <= rd_cnt;
        rdata_s_inf  <= err ? '0 : mem_rdata;
        rresp_s_inf  <= err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        rlast_s_inf  <= (rd_cnt == len);
        rid_s_inf    <= id;
        rvalid_s_inf <= 1'b1;
      end else if (accept && rlast_s_inf) begin
        rvalid_s_inf <= 1'b0;
        rlast_s_inf  <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axi_dram_read_slave.sv
// tb_axi_dram_read_slave: directed + randomized bursts checked against a word-array reference model.
`default_nettype none

module tb_axi_dram_read_slave;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [6:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [15:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic        bd_we;
  logic [11:0] bd_addr;
  logic [15:0] bd_wdata;

  logic [15:0] model [0:4095];
  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  axi_dram_read_slave #(
    .ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(16), .MEM_AW(12), .LATENCY(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .arid_s_inf(arid), .araddr_s_inf(araddr), .arlen_s_inf(arlen),
    .arsize_s_inf(arsize), .arburst_s_inf(arburst), .arvalid_s_inf(arvalid),
    .arready_s_inf(arready), .rid_s_inf(rid), .rdata_s_inf(rdata),
    .rresp_s_inf(rresp), .rlast_s_inf(rlast), .rvalid_s_inf(rvalid),
    .rready_s_inf(rready), .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bd_write(input logic [11:0] a, input logic [15:0] d);
    bd_we    = 1'b1;
    bd_addr  = a;
    bd_wdata = d;
    tick();
    bd_we    = 1'b0;
    model[a] = d;
  endtask

  // Returns just after the handshake edge.
  task automatic ar_handshake(input logic [3:0] id, input logic [31:0] addr, input int len,
                              input logic [1:0] burst, input logic [2:0] size, output bit ok);
    arid    = id;
    araddr  = addr;
    arlen   = 7'(len);
    arburst = burst;
    arsize  = size;
    arvalid = 1'b1;
    ok      = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (arready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (ok) tick();
    else check("ar_timeout", 32'd0, 32'd1);
    arvalid = 1'b0;
  endtask

  function automatic bit ready_pattern(input int mode, input int n);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (n % 3) == 0;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic run_burst(input string tag, input logic [3:0] id, input logic [31:0] addr,
                           input int len, input logic [1:0] burst, input logic [2:0] size,
                           input int mode);
    bit ok, err, first;
    int k, e, n;
    logic [11:0] beat_idx;
    logic [15:0] exp_data;
    ar_handshake(id, addr, len, burst, size, ok);
    if (!ok) return;
    err   = (burst != 2'b01) || (size != 3'b001);
    first = 1'b1;
    k = 0; e = 0; n = 0;
    rready = 1'b0;
    while (k <= len && e < 2000) begin
      tick();
      e++;
      if (e == 1) check({tag, "_arready_busy"}, 32'(arready), 32'd0);
      if (rvalid) begin
        if (first) begin
          check({tag, "_latency"}, 32'(e), 32'(LAT + 1));
          first = 1'b0;
        end
        beat_idx = 12'(((addr >> 1) + 32'(k)) % 4096);
        exp_data = err ? 16'h0000 : model[beat_idx];
        check({tag, "_rdata"}, 32'(rdata), 32'(exp_data));
        check({tag, "_rlast"}, 32'(rlast), 32'(k == len));
        check({tag, "_rid"},   32'(rid),   32'(id));
        check({tag, "_rresp"}, 32'(rresp), err ? 32'h2 : 32'h0);
        rready = ready_pattern(mode, n);
        n++;
        if (rready) k++;
      end
    end
    if (k <= len) begin
      check({tag, "_timeout"}, 32'(k), 32'(len + 1));
      return;
    end
    tick();
    rready = 1'b0;
    check({tag, "_done_rvalid"},  32'(rvalid),  32'd0);
    check({tag, "_done_rlast"},   32'(rlast),   32'd0);
    check({tag, "_done_arready"}, 32'(arready), 32'd1);
  endtask

  initial begin
    int seen;
    bit ok;
    rst_n = 1'b0; arvalid = 1'b1; arid = 4'hA; araddr = 32'h40; arlen = 7'd0;
    arsize = 3'b001; arburst = 2'b01; rready = 1'b0;
    bd_we = 1'b0; bd_addr = '0; bd_wdata = '0;

    // Memory is preloaded while reset is held; it is not affected by reset.
    for (int i = 0; i < 4096; i++) bd_write(12'(i), 16'($urandom));
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_rvalid",  32'(rvalid),  32'd0);
    check("rst_rlast",   32'(rlast),   32'd0);
    check("rst_rid",     32'(rid),     32'd0);
    check("rst_rdata",   32'(rdata),   32'd0);
    check("rst_rresp",   32'(rresp),   32'd0);
    arvalid = 1'b0;
    rst_n = 1'b1;
    tick();
    check("post_rst_arready", 32'(arready), 32'd1);

    bd_write(12'h880, 16'hBEEF);
    run_burst("single", 4'h3, 32'h0000_1100, 0, 2'b01, 3'b001, 0);

    bd_write(12'h010, 16'd1);
    bd_write(12'h011, 16'd2);
    bd_write(12'h012, 16'd3);
    bd_write(12'h013, 16'd4);
    run_burst("bp4", 4'h5, 32'h0000_0020, 3, 2'b01, 3'b001, 1);

    run_burst("wrap", 4'h7, 32'h0000_1FFC, 3, 2'b01, 3'b001, 0);

    run_burst("slverr", 4'h9, 32'h0000_0020, 1, 2'b00, 3'b001, 0);
    run_burst("ok_after_err", 4'h2, 32'h0000_0024, 0, 2'b01, 3'b001, 0);
    run_burst("badsize", 4'h1, 32'h0000_0100, 2, 2'b01, 3'b010, 2);

    for (int r = 0; r < 8; r++) begin
      run_burst("rand", 4'($urandom), $urandom, int'($urandom_range(0, 20)),
                ($urandom_range(0, 5) == 0) ? 2'b10 : 2'b01, 3'b001, 2);
    end
    run_burst("long", 4'hC, 32'h0000_0FF0, 127, 2'b01, 3'b001, 2);

    // Abandon a burst with reset after three beats have been accepted.
    ar_handshake(4'h6, 32'h0000_0200, 7, 2'b01, 3'b001, ok);
    rready = 1'b1;
    seen = 0;
    for (int c = 0; c < 40 && seen < 3; c++) begin
      tick();
      if (rvalid) seen++;
    end
    check("midrst_beats_seen", 32'(seen), 32'd3);
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_rvalid",  32'(rvalid),  32'd0);
    check("midrst_rlast",   32'(rlast),   32'd0);
    check("midrst_rdata",   32'(rdata),   32'd0);
    check("midrst_arready", 32'(arready), 32'd0);
    rready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("midrst_no_stale", 32'(rvalid), 32'd0);
    end
    run_burst("after_rst", 4'hE, 32'h0000_0202, 0, 2'b01, 3'b001, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
